// File: rtl/mul8_shift_add_pkg.sv
// mul8_shift_add_pkg: shared state encoding and sizing constants for the shift-add multiplier
package mul8_shift_add_pkg;
    localparam int MUL_WIDTH = 8;
    localparam int MUL_ITER = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/mul8_shift_add_if.sv
// mul8_shift_add_if: start/done handshake and operand/result bus of the multiplier
interface mul8_shift_add_if;
    import mul8_shift_add_pkg::*;
    logic                       start;
    logic [MUL_WIDTH-1:0]       a;
    logic [MUL_WIDTH-1:0]       b;
    logic                       ready;
    logic                       busy;
    logic                       done;
    logic [2*MUL_WIDTH-1:0]     product;
    modport master (output start, a, b, input ready, busy, done, product);
    modport slave (input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/full_adder_8bit.sv
// full_adder_8bit: 8-bit ripple-carry adder
module full_adder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [8:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    assign o_cout = w_c[8];
endmodule

// File: rtl/mul8_shift_add.sv
// mul8_shift_add: sequential unsigned 8x8->16 shift-add multiplier, fixed 8-iteration latency
module mul8_shift_add
    import mul8_shift_add_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int ITER  = MUL_ITER
) (
    input  logic               clk,
    input  logic               rst,
    mul8_shift_add_if.slave    bus
);
    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH-1:0]   r_aq;
    logic [3:0]           r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     w_addend, w_sum;
    logic                 w_cout, w_load, w_last;
    logic [2*WIDTH-1:0]   w_shift;

    assign w_addend = r_aq[0] ? r_m : '0;

    full_adder_8bit u_add (
        .i_a    (r_aq[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // C is shifted straight into A[7], so the post-shift C bit is always zero and needs no storage
    assign w_shift = {w_cout, w_sum, r_aq[WIDTH-1:1]};
    assign w_load  = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_last  = r_count == 4'(ITER - 1);

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_aq      <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_m     <= bus.a;
                r_aq    <= {{WIDTH{1'b0}}, bus.b};
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_aq    <= w_shift;
                r_count <= r_count + 4'd1;
                if (w_last) r_product <= w_shift;
            end
        end
    end

    assign bus.ready   = r_state == IDLE || r_state == DONE;
    assign bus.busy    = r_state == RUN;
    assign bus.done    = r_state == DONE;
    assign bus.product = r_product;
endmodule

// File: tb/tb_mul8_shift_add.sv
// tb_mul8_shift_add: table-driven and directed checks of the shift-add multiplier
module tb_mul8_shift_add;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    mul8_shift_add_if m_if ();
    mul8_shift_add dut (.clk(clk), .rst(rst), .bus(m_if.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for the edge E0; returns sampled just after E0
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        m_if.start = 1'b1;
        m_if.a = a;
        m_if.b = b;
        tick();
        m_if.start = 1'b0;
        m_if.a = 8'hxx;
        m_if.b = 8'hxx;
    endtask

    // Called just after E0: counts busy samples and the edge on which done appears
    task automatic wait_done(output int lat, output int busy_n, output int pulses);
        lat = -1;
        busy_n = m_if.busy ? 1 : 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_if.busy) busy_n++;
            if (m_if.done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (lat >= 0) break;
        end
    endtask

    initial begin
        vec_t vec[8];
        int lat, busy_n, pulses;
        vec[0] = '{8'd13, 8'd11, 16'h008F};
        vec[1] = '{8'd255, 8'd255, 16'hFE01};
        vec[2] = '{8'd0, 8'd200, 16'h0000};
        vec[3] = '{8'd200, 8'd0, 16'h0000};
        vec[4] = '{8'd1, 8'd1, 16'h0001};
        vec[5] = '{8'd128, 8'd2, 16'h0100};
        vec[6] = '{8'd15, 8'd17, 16'h00FF};
        vec[7] = '{8'd170, 8'd85, 16'h3872};
        m_if.start = 1'b0;
        m_if.a = 8'h00;
        m_if.b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ready", 32'(m_if.ready), 32'd1);
        chk("reset busy", 32'(m_if.busy), 32'd0);
        chk("reset done", 32'(m_if.done), 32'd0);
        chk("reset product", 32'(m_if.product), 32'h0);

        for (int k = 0; k < 8; k++) begin
            launch(vec[k].a, vec[k].b);
            wait_done(lat, busy_n, pulses);
            chk($sformatf("vec%0d latency", k), 32'(lat), 32'd8);
            chk($sformatf("vec%0d busy cycles", k), 32'(busy_n), 32'd8);
            chk($sformatf("vec%0d product", k), 32'(m_if.product), 32'(vec[k].p));
            chk($sformatf("vec%0d ready in done", k), 32'(m_if.ready), 32'd1);
            tick();
            chk($sformatf("vec%0d done single", k), 32'(m_if.done), 32'd0);
            if (k == 0) begin
                for (int i = 0; i < 4; i++) tick();
                chk("vec0 product held", 32'(m_if.product), 32'h008F);
            end
        end

        // start while busy is ignored
        launch(8'd3, 8'd5);
        tick();
        tick();
        m_if.start = 1'b1;
        m_if.a = 8'd9;
        m_if.b = 8'd9;
        tick();
        m_if.start = 1'b0;
        chk("ignore busy held", 32'(m_if.busy), 32'd1);
        pulses = 0;
        lat = -1;
        for (int i = 4; i <= 20; i++) begin
            if (m_if.done) begin
                pulses++;
                if (lat < 0) lat = i - 1;
            end
            tick();
        end
        chk("ignore latency", 32'(lat), 32'd8);
        chk("ignore done pulses", 32'(pulses), 32'd1);
        chk("ignore product", 32'(m_if.product), 32'h000F);

        // reset mid-RUN discards the operation
        launch(8'd7, 8'd6);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", 32'(m_if.busy), 32'd0);
        chk("midrst ready", 32'(m_if.ready), 32'd1);
        chk("midrst product", 32'(m_if.product), 32'h0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_if.done) pulses++;
            tick();
        end
        chk("midrst no done", 32'(pulses), 32'd0);
        launch(8'd2, 8'd2);
        wait_done(lat, busy_n, pulses);
        chk("after rst latency", 32'(lat), 32'd8);
        chk("after rst product", 32'(m_if.product), 32'h0004);
        tick();

        // back-to-back: start held in the DONE cycle
        launch(8'd10, 8'd10);
        wait_done(lat, busy_n, pulses);
        chk("b2b first latency", 32'(lat), 32'd8);
        chk("b2b first product", 32'(m_if.product), 32'h0064);
        launch(8'd4, 8'd4);
        chk("b2b busy no bubble", 32'(m_if.busy), 32'd1);
        chk("b2b product held in run", 32'(m_if.product), 32'h0064);
        wait_done(lat, busy_n, pulses);
        chk("b2b second latency", 32'(lat), 32'd8);
        chk("b2b second product", 32'(m_if.product), 32'h0010);
        tick();

        // rst together with start: rst wins
        rst = 1'b1;
        launch(8'd5, 8'd5);
        rst = 1'b0;
        chk("rst+start busy", 32'(m_if.busy), 32'd0);
        chk("rst+start ready", 32'(m_if.ready), 32'd1);
        chk("rst+start product", 32'(m_if.product), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
